// File: rtl/aes_iter_core.sv
// Iterative AES-128/AES-256 encryption core. One round per clock. The round
// keys are expanded on the fly from a sliding key window.

module aes_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);
   // Forward S-box, entry 0 in the most significant byte
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [10:0] bit_idx;

   // Entry n sits (255-n) bytes above bit 0, so the bit offset is ~n * 8
   always_comb begin
      bit_idx  = {~in_byte, 3'b000};
      out_byte = SBOX_TBL[bit_idx +: 8];
   end
endmodule

module aes_iter_core #(
   parameter int KEY_BITS = 256
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [127:0]        in_state,
   input  logic [KEY_BITS-1:0] in_key,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        out_data
);
   localparam logic [3:0] NR = (KEY_BITS == 128) ? 4'd10 : 4'd14;

   if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
      $fatal(1, "aes_iter_core: KEY_BITS must be 128 or 256");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state_q, state_d;
   logic [127:0]        st_q, st_d;
   logic [KEY_BITS-1:0] kw_q, kw_d;
   logic [3:0]          rnd_q, rnd_d;
   logic [7:0]          rcon_q, rcon_d;

   logic [127:0]        sub_bytes, shift_rows, mix_cols, round_key;
   logic [31:0]         key_sub, key_t, nw0, nw1, nw2, nw3;
   logic [127:0]        key_new;
   logic [KEY_BITS-1:0] kw_step;
   logic                use_rot, is_last;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   for (genvar i = 0; i < 16; i++) begin : g_state_sbox
      aes_sbox u_sbox (.in_byte(st_q[127-8*i -: 8]), .out_byte(sub_bytes[127-8*i -: 8]));
   end

   for (genvar i = 0; i < 4; i++) begin : g_key_sbox
      aes_sbox u_sbox (.in_byte(kw_q[31-8*i -: 8]), .out_byte(key_sub[31-8*i -: 8]));
   end

   // ShiftRows: row r of column c comes from column (c+r) mod 4
   always_comb begin
      shift_rows = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shift_rows[127-8*(4*c+r) -: 8] = sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
   end

   // MixColumns on each of the four shifted columns
   always_comb begin
      mix_cols = '0;
      for (int c = 0; c < 4; c++) begin
         mix_cols[127-32*c -: 32] = mix_column(shift_rows[127-32*c -: 32]);
      end
   end

   // One key step from the newest window word; AES-256 odd rounds skip RotWord and rcon
   always_comb begin
      use_rot = (KEY_BITS == 128) || !rnd_q[0];
      is_last = (rnd_q == NR);
      key_t   = use_rot ? ({key_sub[23:0], key_sub[31:24]} ^ {rcon_q, 24'h000000}) : key_sub;
      nw0     = kw_q[KEY_BITS-1 -: 32] ^ key_t;
      nw1     = kw_q[KEY_BITS-33 -: 32] ^ nw0;
      nw2     = kw_q[KEY_BITS-65 -: 32] ^ nw1;
      nw3     = kw_q[KEY_BITS-97 -: 32] ^ nw2;
      key_new = {nw0, nw1, nw2, nw3};
   end

   if (KEY_BITS == 128) begin : g_ks128
      assign round_key = key_new;
      assign kw_step   = key_new;
   end else begin : g_ks256
      // Round 1 uses the second half of the cipher key as-is
      assign round_key = (rnd_q == 4'd1) ? kw_q[127:0] : key_new;
      assign kw_step   = (rnd_q == 4'd1) ? kw_q : {kw_q[127:0], key_new};
   end

   // Next-state and register updates for IDLE / RUN / DONE
   always_comb begin
      state_d = state_q;
      st_d    = st_q;
      kw_d    = kw_q;
      rnd_d   = rnd_q;
      rcon_d  = rcon_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               st_d    = in_state ^ in_key[KEY_BITS-1 -: 128];
               kw_d    = in_key;
               rnd_d   = 4'd1;
               rcon_d  = 8'h01;
               state_d = RUN;
            end
         end
         RUN: begin
            st_d  = (is_last ? shift_rows : mix_cols) ^ round_key;
            kw_d  = kw_step;
            rnd_d = rnd_q + 4'd1;
            if (use_rot && !is_last) begin
               rcon_d = xtime(rcon_q);
            end
            if (is_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset discards any block in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         st_q    <= '0;
         kw_q    <= '0;
         rnd_q   <= '0;
         rcon_q  <= '0;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         kw_q    <= kw_d;
         rnd_q   <= rnd_d;
         rcon_q  <= rcon_d;
      end
   end

   // Handshake outputs are pure state decodes
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      out_data  = (state_q == DONE) ? st_q : '0;
   end
endmodule

// File: tb/tb_aes_iter_core.sv
// Self-checking bench for aes_iter_core: known answers for AES-128/256,
// backpressure, busy-input ignore, reset mid-block and random streams
// checked against an independent AES reference model.

module tb_aes_iter_core;
   localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [255:0] KEY_B  = 256'h0f1e2d3c4b5a69788796a5b4c3d2e1f0ffeeddccbbaa99887766554433221100;
   localparam logic [127:0] PT_B   = 128'hcafebabedeadbeef0123456789abcdef;
   localparam int NUM_STREAM = 100;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [127:0] in_state, out_data;
   logic [255:0] in_key;
   logic         in_valid_128, in_ready_128, out_valid_128, out_ready_128;
   logic [127:0] in_state_128, out_data_128, in_key_128;

   logic [7:0]   sbox_ref [256];
   logic [127:0] exp_q [$];
   int           checks = 0;
   int           errors = 0;

   aes_iter_core #(.KEY_BITS(256)) dut256 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_state(in_state), .in_key(in_key), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data));

   aes_iter_core #(.KEY_BITS(128)) dut128 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_128), .in_ready(in_ready_128),
      .in_state(in_state_128), .in_key(in_key_128), .out_valid(out_valid_128),
      .out_ready(out_ready_128), .out_data(out_data_128));

   always #5 clk = ~clk;

   // Hard time limit so a hung handshake still ends the run
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got time limit reached, expected run to finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   // S-box derived from the GF(2^8) inverse and the affine map, not from a table
   task automatic build_sbox;
      logic [7:0] inv, xb, yb;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         xb  = 8'(x);
         for (int y = 1; y < 256; y++) begin
            yb = 8'(y);
            if (gmul(xb, yb) == 8'h01) inv = yb;
         end
         sbox_ref[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                       {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
   endfunction

   function automatic logic [7:0] wbyte(input logic [31:0] w, input int j);
      logic [31:0] t;
      t = w >> (8 * (3 - j));
      return t[7:0];
   endfunction

   // Full FIPS-197 key expansion then cipher; 128-bit keys are left-aligned in key
   function automatic logic [127:0] aes_ref(input logic [255:0] key, input int nk, input logic [127:0] pt);
      logic [31:0]  w [60];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3, rc;
      logic [31:0]  tmp;
      logic [255:0] k;
      logic [127:0] p, res;
      int nr;
      nr = nk + 6;
      k = key;
      for (int i = 0; i < nk; i++) begin
         w[i] = k[255:224];
         k = k << 32;
      end
      rc = 8'h01;
      for (int i = nk; i < 4 * (nr + 1); i++) begin
         tmp = w[i-1];
         if (i % nk == 0) begin
            tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            tmp = sub_word(tmp);
         end
         w[i] = w[i-nk] ^ tmp;
      end
      p = pt;
      for (int i = 0; i < 16; i++) begin
         s[i] = p[127:120] ^ wbyte(w[i/4], i % 4);
         p = p << 8;
      end
      for (int r = 1; r <= nr; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox_ref[s[i]];
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++) s[4*c+q] = t[4*((c+q)%4)+q];
         if (r < nr) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ wbyte(w[4*r + i/4], i % 4);
      end
      res = '0;
      for (int i = 0; i < 16; i++) res = {res[119:0], s[i]};
      return res;
   endfunction

   // ---------------- helpers ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Wait for out_valid on the 256-bit core, counting cycles where in_ready was high
   task automatic wait_out(input int limit, output int cyc, output int rdy);
      cyc = 0;
      rdy = 0;
      while (!out_valid && cyc < limit) begin
         if (in_ready) rdy++;
         tick();
         cyc++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid); end
      checks++; if (out_data !== 128'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h, expected 0", out_data); end
      checks++; if (in_ready_128 !== 1'b1 || out_valid_128 !== 1'b0) begin errors++; $display("[TB] FAIL reset_128: got ready %b valid %b, expected 1 0", in_ready_128, out_valid_128); end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_kat256;
      int cyc, rdy;
      logic [127:0] exp;
      out_ready = 1'b1;
      exp_q.push_back(CT256);
      in_key = KEY256; in_state = PT; in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL kat256_accept_ready: got %b, expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      wait_out(40, cyc, rdy);
      checks++; if (cyc != 14) begin errors++; $display("[TB] FAIL kat256_latency: got %0d, expected 14", cyc); end
      checks++; if (rdy != 0) begin errors++; $display("[TB] FAIL kat256_busy_ready: got %0d ready cycles, expected 0", rdy); end
      exp = exp_q.pop_front();
      checks++; if (out_data !== exp) begin errors++; $display("[TB] FAIL kat256_data: got %h, expected %h", out_data, exp); end
      tick();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL kat256_release: got valid %b ready %b, expected 0 1", out_valid, in_ready); end
   endtask

   task automatic test_kat128;
      int cyc;
      logic [127:0] exp;
      out_ready_128 = 1'b1;
      exp_q.push_back(CT128);
      in_key_128 = KEY128; in_state_128 = PT; in_valid_128 = 1'b1;
      tick();
      in_valid_128 = 1'b0;
      cyc = 0;
      while (!out_valid_128 && cyc < 40) begin tick(); cyc++; end
      checks++; if (cyc != 10) begin errors++; $display("[TB] FAIL kat128_latency: got %0d, expected 10", cyc); end
      exp = exp_q.pop_front();
      checks++; if (out_data_128 !== exp) begin errors++; $display("[TB] FAIL kat128_data: got %h, expected %h", out_data_128, exp); end
      tick();
      checks++; if (out_valid_128 !== 1'b0 || in_ready_128 !== 1'b1) begin errors++; $display("[TB] FAIL kat128_release: got valid %b ready %b, expected 0 1", out_valid_128, in_ready_128); end
   endtask

   task automatic test_backpressure;
      int cyc, rdy, bad;
      logic [127:0] exp;
      out_ready = 1'b0;
      exp_q.push_back(CT256);
      in_key = KEY256; in_state = PT; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_out(40, cyc, rdy);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_valid: got %b, expected 1", out_valid); end
      exp = exp_q.pop_front();
      bad = 0;
      for (int i = 0; i < 7; i++) begin
         if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) bad++;
         tick();
      end
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL bp_hold: got %0d unstable cycles, expected 0", bad); end
      checks++; if (out_data !== exp) begin errors++; $display("[TB] FAIL bp_data: got %h, expected %h", out_data, exp); end
      out_ready = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got ready %b valid %b, expected 1 0", in_ready, out_valid); end
   endtask

   task automatic test_busy_ignore;
      int edges, accept_edge, cyc, rdy;
      logic got_a;
      logic [127:0] exp;
      out_ready = 1'b1;
      exp_q.push_back(CT256);
      in_key = KEY256; in_state = PT; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      edges = 0; accept_edge = -1; got_a = 1'b0;
      repeat (3) begin tick(); edges++; end
      in_key = KEY_B; in_state = PT_B; in_valid = 1'b1;
      while (edges < 60 && accept_edge < 0) begin
         if (out_valid && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++; if (out_data !== exp) begin errors++; $display("[TB] FAIL busy_first_data: got %h, expected %h", out_data, exp); end
            got_a = 1'b1;
         end
         if (in_ready) begin
            accept_edge = edges + 1;
            exp_q.push_back(aes_ref(KEY_B, 8, PT_B));
         end
         tick();
         edges++;
      end
      in_valid = 1'b0;
      checks++; if (got_a !== 1'b1) begin errors++; $display("[TB] FAIL busy_first_seen: got %b, expected 1", got_a); end
      checks++; if (accept_edge != 16) begin errors++; $display("[TB] FAIL busy_accept_edge: got %0d, expected 16", accept_edge); end
      wait_out(40, cyc, rdy);
      if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = '0;
      checks++; if (out_data !== exp) begin errors++; $display("[TB] FAIL busy_second_data: got %h, expected %h", out_data, exp); end
      tick();
   endtask

   task automatic test_reset_mid;
      int cyc, rdy, stray;
      out_ready = 1'b1;
      in_key = KEY256; in_state = PT; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_run_ready: got %b, expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0 || out_data !== 128'h0) begin errors++; $display("[TB] FAIL rst_run_out: got valid %b data %h, expected 0 0", out_valid, out_data); end
      tick();
      rst_n = 1'b1;
      stray = 0;
      repeat (20) begin tick(); if (out_valid || !in_ready) stray++; end
      checks++; if (stray != 0) begin errors++; $display("[TB] FAIL rst_residue: got %0d busy cycles, expected 0", stray); end
      // Reset while a finished block is waiting on out_ready
      out_ready = 1'b0;
      in_key = KEY256; in_state = PT; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_out(40, cyc, rdy);
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || out_data !== 128'h0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_done: got valid %b data %h ready %b, expected 0 0 1", out_valid, out_data, in_ready); end
      tick();
      rst_n = 1'b1;
      tick();
      test_kat256();
   endtask

   task automatic test_back_to_back;
      int recvd, guard, cguard, gap;
      logic [255:0] k;
      logic [127:0] p, exp;
      recvd = 0;
      out_ready = 1'b0;
      fork
         begin
            for (int n = 0; n < NUM_STREAM; n++) begin
               gap = $urandom_range(0, 3);
               repeat (gap) tick();
               k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
               p = {$urandom, $urandom, $urandom, $urandom};
               in_key = k; in_state = p; in_valid = 1'b1;
               guard = 0;
               while (!in_ready && guard < 200) begin tick(); guard++; end
               exp_q.push_back(aes_ref(k, 8, p));
               tick();
               in_valid = 1'b0;
            end
         end
         begin
            cguard = 0;
            while (recvd < NUM_STREAM && cguard < 20000) begin
               out_ready = ($urandom_range(0, 2) != 0);
               if (out_valid && out_ready) begin
                  if (exp_q.size() == 0) begin
                     checks++; errors++;
                     $display("[TB] FAIL stream_extra: got output %h, expected none pending", out_data);
                  end else begin
                     exp = exp_q.pop_front();
                     checks++; if (out_data !== exp) begin errors++; $display("[TB] FAIL stream_data[%0d]: got %h, expected %h", recvd, out_data, exp); end
                  end
                  recvd++;
               end
               tick();
               cguard++;
            end
         end
      join
      out_ready = 1'b1;
      checks++; if (recvd != NUM_STREAM) begin errors++; $display("[TB] FAIL stream_count: got %0d, expected %0d", recvd, NUM_STREAM); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL stream_leftover: got %0d, expected 0", exp_q.size()); end
      repeat (3) tick();
   endtask

   task automatic test_stream_128;
      int cyc;
      logic [127:0] k, p, exp;
      out_ready_128 = 1'b1;
      for (int n = 0; n < 12; n++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         p = {$urandom, $urandom, $urandom, $urandom};
         exp_q.push_back(aes_ref({k, 128'h0}, 4, p));
         in_key_128 = k; in_state_128 = p; in_valid_128 = 1'b1;
         tick();
         in_valid_128 = 1'b0;
         cyc = 0;
         while (!out_valid_128 && cyc < 30) begin tick(); cyc++; end
         exp = exp_q.pop_front();
         checks++; if (out_data_128 !== exp || cyc != 10) begin errors++; $display("[TB] FAIL stream128[%0d]: got %h after %0d, expected %h after 10", n, out_data_128, cyc, exp); end
         tick();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_state = '0; in_key = '0; out_ready = 1'b1;
      in_valid_128 = 1'b0; in_state_128 = '0; in_key_128 = '0; out_ready_128 = 1'b1;
      build_sbox();
      test_reset();
      test_kat256();
      test_kat128();
      test_backpressure();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      test_stream_128();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
